rf_read_arbiter: RTL and testbench
==================================

# rf_read_arbiter

Sequencing controller that shares one register-file read path (a 32-to-1, 32-bit read mux driven by a 5-bit select) among several requesters in the processor. Accepts register-read requests over a valid/ready handshake, grants them round-robin, drives the mux select for one stable cycle, captures the mux output and returns it on a single response channel with requester ID. Sits between the register file's read mux and the units that need extra register reads (debug port, multi-cycle ops, exception logic).

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 32, register width
- ADDR_W, 5, register index width (mux select width)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_addr  in  NREQ*ADDR_W  per-requester register index; requester i at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NREQ  one-hot grant/accept; request i transfers when req_valid[i] && req_ready[i]
- mux_sel  out  ADDR_W  select to the shared read mux
- mux_q  in  DATA_W  read-mux output (combinational from mux_sel)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  DATA_W  register value read
- rsp_id  out  clog2(NREQ)  index of requester the response belongs to

## Operation
- States: IDLE, READ, RESP.
- IDLE: if any req_valid, pick winner g = first set bit searching from rr_ptr upward with wrap; req_ready[g]=1 (combinational, only in IDLE, at most one bit); register sel_q<=req_addr[g], id_q<=g; go READ. No request: stay, req_ready=0.
- READ: mux_sel=sel_q; data_q<=mux_q; go RESP.
- RESP: rsp_valid=1, rsp_data=data_q, rsp_id=id_q; hold all three stable until rsp_ready. On rsp_ready: rr_ptr<=(id_q+1) mod NREQ; go IDLE.
- mux_sel is always sel_q (registered, glitch-free); holds last value outside READ.
- Requests are not accepted in READ or RESP; req_valid must be held by requester until accepted; req_addr sampled only at acceptance.
- rr_ptr advances only on response completion, guaranteeing fairness: a continuously-valid requester waits at most NREQ-1 grants.
- Reset in any state: return to IDLE, pending transaction discarded, no response emitted.

## Timing
- Reset values: state IDLE, rr_ptr 0, sel_q 0, id_q 0, data_q 0; req_ready 0, mux_sel 0, rsp_valid 0, rsp_data 0, rsp_id 0.
- Accept in cycle T -> mux_sel valid T+1 -> rsp_valid first high T+2 (latency 2).
- Peak throughput one read per 3 cycles (rsp_ready tied high).
- rsp_ready high in cycle of completion: new acceptance earliest the next cycle (IDLE), never same cycle.
- rsp_ready asserted while rsp_valid low: ignored.

## Configuration
- RF_ARB_ZERO_REG_EN defined: accepted request with address 0 skips READ; IDLE goes directly to RESP with data_q<=0 (latency 1); mux_sel not updated for that request (sel_q keeps previous value).
- Undefined: address 0 read through the mux like any other register, latency 2.

## Structure
- Shared package rf_arb_pkg: state encoding constants (IDLE/READ/RESP), DATA_W and ADDR_W defaults, ID width function.
- One sub-module: rr_pick — combinational round-robin picker (inputs: valid vector, rr_ptr; outputs: one-hot grant, grant index, any).

## Test plan
- Single request: req_valid[2]=1, addr=7, mux models reg[i]=0x1000+i, rsp_ready=1 -> req_ready[2] in T, mux_sel=7 in T+1, rsp_valid T+2 with rsp_data=0x1007, rsp_id=2.
- All 4 requesters continuously valid, addr=i+1 -> grant order 0,1,2,3,0 after reset; one response every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, req_ready all 0, no new grant; completes cycle rsp_ready=1.
- rst asserted during READ -> next cycle all outputs at reset values, rr_ptr 0, no response for the aborted read.
- Addr 0 with mux driving 0xDEADBEEF: with RF_ARB_ZERO_REG_EN -> rsp_data=0 at T+1; without -> rsp_data=0xDEADBEEF at T+2.
- Requesters 1 and 3 valid, rr_ptr=2 after serving 1 -> next grant 3, then 1 (wrap).

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types, width defaults and helpers for the register-file read arbiter.
package rf_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NREQ_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_read_arbiter_if.sv
// Request/response handshake bundle between requesters and the read arbiter.
interface rf_read_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  localparam int unsigned ID_W = id_width(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_W-1:0]      rsp_data;
  logic [ID_W-1:0]        rsp_id;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/rf_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr, with wrap.
module rr_pick
  import rf_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && valid[ID_W'(j)]) begin
        any               = 1'b1;
        grant[ID_W'(j)]   = 1'b1;
        idx               = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NREQ requesters.
// Optional feature macro: RF_ARB_ZERO_REG_EN (address 0 returns zero without a mux read).
module rf_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  rf_read_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] mux_sel,
  input  logic [DATA_W-1:0] mux_q
);

  localparam int unsigned ID_W = id_width(NREQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [NREQ-1:0]   pick_grant;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] pick_addr;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Address of the current round-robin winner.
  always_comb begin
    pick_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == ID_W'(i)) pick_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  // Next-state, grant and capture decisions.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    id_d          = id_q;
    data_d        = data_q;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          bus.req_ready = pick_grant;
          id_d          = pick_idx;
`ifdef RF_ARB_ZERO_REG_EN
          if (pick_addr == '0) begin
            data_d  = '0;
            state_d = RESP;
          end else begin
            sel_d   = pick_addr;
            state_d = READ;
          end
`else
          sel_d   = pick_addr;
          state_d = READ;
`endif
        end
      end
      READ: begin
        data_d  = mux_q;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          ptr_d   = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response fields come straight from registers, so they hold under backpressure.
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign mux_sel       = sel_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed self-checking bench for rf_read_arbiter (NREQ=4, DATA_W=32, ADDR_W=5).
module tb_rf_read_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  mux_sel;
  logic [31:0] mux_q;
  logic        mux_dead;
  int          n_tests;
  int          n_fail;

  rf_read_arbiter_if #(.NREQ(4), .DATA_W(32), .ADDR_W(5)) bus ();

  rf_read_arbiter #(.NREQ(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mux_sel (mux_sel),
    .mux_q   (mux_q)
  );

  // Register file model: reg[i] = 0x1000 + i, or a fixed poison value.
  assign mux_q = mux_dead ? 32'hDEADBEEF : 32'h1000 + 32'(mux_sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    bus.req_addr[i*5 +: 5] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.rsp_ready = 1'b0;
    do_reset();
    #1;
    n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
    n_tests++; if (mux_sel !== 5'd0) begin n_fail++; $display("FAIL reset_mux_sel got %0d exp 0", mux_sel); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
    n_tests++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got %0d exp 0", bus.rsp_id); end
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_addr(2, 5'd7);
    bus.req_valid = 4'b0100;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b exp 0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    #1;
    n_tests++; if (mux_sel !== 5'd7) begin n_fail++; $display("FAIL single_mux_sel got %0d exp 7", mux_sel); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp got %b exp 0", bus.rsp_valid); end
    step();
    n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got %b exp 1", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 32'h1007) begin n_fail++; $display("FAIL single_rsp_data got %h exp 1007", bus.rsp_data); end
    n_tests++; if (bus.rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp_id got %0d exp 2", bus.rsp_id); end
    step();
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop got %b exp 0", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_grant;
    logic [31:0] exp_data;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_grant = 4'b0001 << (k % 4);
      exp_data  = 32'h1000 + 32'((k % 4) + 1);
      #1;
      n_tests++; if (bus.req_ready !== exp_grant) begin n_fail++; $display("FAIL rr_grant[%0d] got %b exp %b", k, bus.req_ready, exp_grant); end
      step();
      n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_ready_in_read[%0d] got %b exp 0000", k, bus.req_ready); end
      step();
      n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data || bus.rsp_id !== 2'(k % 4))
        begin n_fail++; $display("FAIL rr_rsp[%0d] got v=%b d=%h id=%0d exp v=1 d=%h id=%0d", k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, exp_data, k % 4); end
      step();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.rsp_ready = 1'b0;
    set_addr(0, 5'd4);
    set_addr(1, 5'd9);
    bus.req_valid = 4'b0011;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant got %b exp 0001", bus.req_ready); end
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1004 || bus.rsp_id !== 2'd0 || bus.req_ready !== 4'b0000)
        begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d rdy=%b exp v=1 d=00001004 id=0 rdy=0000", c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready); end
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_complete_valid got %b exp 1", bus.rsp_valid); end
    step();
    n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_next_grant got %b exp 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    step();
    n_tests++; if (bus.rsp_data !== 32'h1009 || bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_second_rsp got d=%h id=%0d exp d=00001009 id=1", bus.rsp_data, bus.rsp_id); end
    step();
  endtask

  task automatic test_reset_in_read();
    set_addr(3, 5'd12);
    bus.req_valid = 4'b1000;
    #1;
    n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL rst_read_grant got %b exp 1000", bus.req_ready); end
    step();
    bus.req_valid = '0;
    n_tests++; if (mux_sel !== 5'd12) begin n_fail++; $display("FAIL rst_read_mux_sel got %0d exp 12", mux_sel); end
    rst = 1'b1;
    step();
    n_tests++; if (mux_sel !== 5'd0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 2'd0 || bus.req_ready !== 4'b0000)
      begin n_fail++; $display("FAIL rst_read_outputs got sel=%0d v=%b d=%h id=%0d rdy=%b exp all zero", mux_sel, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready); end
    rst = 1'b0;
    step();
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_read_no_rsp1 got %b exp 0", bus.rsp_valid); end
    step();
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_read_no_rsp2 got %b exp 0", bus.rsp_valid); end
    bus.req_valid = 4'b1111;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_read_ptr_zero got %b exp 0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.rsp_ready = 1'b1;
    set_addr(1, 5'd5);
    set_addr(3, 5'd6);
    bus.req_valid = 4'b0010;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_first got %b exp 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    step();
    step();
    bus.req_valid = 4'b1010;
    #1;
    n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant3 got %b exp 1000", bus.req_ready); end
    step();
    bus.req_valid = 4'b0010;
    step();
    n_tests++; if (bus.rsp_data !== 32'h1006 || bus.rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_rsp3 got d=%h id=%0d exp d=00001006 id=3", bus.rsp_data, bus.rsp_id); end
    step();
    n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_grant1 got %b exp 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    step();
    n_tests++; if (bus.rsp_data !== 32'h1005 || bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL wrap_rsp1 got d=%h id=%0d exp d=00001005 id=1", bus.rsp_data, bus.rsp_id); end
    step();
  endtask

  task automatic test_zero_reg();
    mux_dead = 1'b1;
    bus.rsp_ready = 1'b1;
    set_addr(0, 5'd0);
    bus.req_valid = 4'b0001;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL zero_grant got %b exp 0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
`ifdef RF_ARB_ZERO_REG_EN
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 2'd0)
      begin n_fail++; $display("FAIL zero_fast_rsp got v=%b d=%h id=%0d exp v=1 d=0 id=0", bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
    n_tests++; if (mux_sel !== 5'd5) begin n_fail++; $display("FAIL zero_sel_kept got %0d exp 5", mux_sel); end
    step();
`else
    n_tests++; if (mux_sel !== 5'd0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL zero_read got sel=%0d v=%b exp sel=0 v=0", mux_sel, bus.rsp_valid); end
    step();
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL zero_mux_rsp got v=%b d=%h exp v=1 d=deadbeef", bus.rsp_valid, bus.rsp_data); end
    step();
`endif
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL zero_done got %b exp 0", bus.rsp_valid); end
    mux_dead = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    mux_dead      = 1'b0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_in_read();
    test_wrap();
    test_zero_reg();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
